// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard and flush controller for the 5-stage core.
//
// Generates the per-stage write enables (*_Wr) and flushes (*_Flush) for the
// IF/ID/EXE/MEM/WB pipeline registers.
//
// It resolves the following hazards and events:
//   - load-use hazards
//   - multi-cycle MDU stalls
//   - I/D-cache stalls
//   - branch-likely annulment
//   - WB-stage exceptions
//
// An exception that arrives while the D-cache is busy is held in S_EXC_WAIT
// until the access completes. The one-cycle MDU abort pulse follows every
// exception flush by one cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ID_rs/ID_rt           source fields of the ID instruction
//   ID_ReadRs/ID_ReadRt   ID instruction actually reads rs / rt
//   EXE_IsLoad, EXE_rt    EXE load and its destination register
//   EXE_MDUStall          MDU result not ready
//   EXE_BrLikelyAnnul     annul the delay slot currently in ID
//   IF_ICacheStall        fetch not ready
//   MEM_DCacheStall       data access in MEM not complete
//   WB_ExceptValid        exception committed in WB
//   PC_Wr..WB_Wr          stage register write enables
//   ID_Flush..WB_Flush    stage register flushes (override write enables)
//   Exc_Redirect          PC loads the exception vector this cycle
//   MDU_Flush             registered one-cycle MDU abort pulse
//   Cnt_*                 stall performance counters
//
// Optional feature macro: PIPE_STALL_CNT_EN (defined = counters implemented,
// undefined = Cnt_* tied to zero).
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_ReadRs,
  input  logic             ID_ReadRt,
  input  logic             EXE_IsLoad,
  input  logic [4:0]       EXE_rt,
  input  logic             EXE_MDUStall,
  input  logic             EXE_BrLikelyAnnul,
  input  logic             IF_ICacheStall,
  input  logic             MEM_DCacheStall,
  input  logic             WB_ExceptValid,
  output logic             PC_Wr,
  output logic             ID_Wr,
  output logic             EXE_Wr,
  output logic             MEM_Wr,
  output logic             WB_Wr,
  output logic             ID_Flush,
  output logic             EXE_Flush,
  output logic             MEM_Flush,
  output logic             WB_Flush,
  output logic             Exc_Redirect,
  output logic             MDU_Flush,
  output logic [CNT_W-1:0] Cnt_DStall,
  output logic [CNT_W-1:0] Cnt_MDUStall,
  output logic [CNT_W-1:0] Cnt_LoadUse,
  output logic [CNT_W-1:0] Cnt_Exc
);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_EXC_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_mdu_flush;
  logic   w_exc_action;
  logic   w_load_use;

  // r0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign w_load_use = EXE_IsLoad && (EXE_rt != 5'd0) &&
                      ((ID_ReadRs && (ID_rs == EXE_rt)) ||
                       (ID_ReadRt && (ID_rt == EXE_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_mdu_flush <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mdu_flush <= w_exc_action;
    end
  end

  assign MDU_Flush = r_mdu_flush;

  always_comb begin
    PC_Wr        = 1'b1;
    ID_Wr        = 1'b1;
    EXE_Wr       = 1'b1;
    MEM_Wr       = 1'b1;
    WB_Wr        = 1'b1;
    ID_Flush     = 1'b0;
    EXE_Flush    = 1'b0;
    MEM_Flush    = 1'b0;
    WB_Flush     = 1'b0;
    Exc_Redirect = 1'b0;
    w_exc_action = 1'b0;
    w_state_nxt  = r_state;

    case (r_state)
      S_RUN: begin
        if (WB_ExceptValid && MEM_DCacheStall) begin
          // Freeze everything; the flush is deferred until the access ends.
          PC_Wr       = 1'b0;
          ID_Wr       = 1'b0;
          EXE_Wr      = 1'b0;
          MEM_Wr      = 1'b0;
          WB_Wr       = 1'b0;
          w_state_nxt = S_EXC_WAIT;
        end else if (WB_ExceptValid) begin
          w_exc_action = 1'b1;
        end else if (MEM_DCacheStall) begin
          PC_Wr    = 1'b0;
          ID_Wr    = 1'b0;
          EXE_Wr   = 1'b0;
          MEM_Wr   = 1'b0;
          WB_Flush = 1'b1;
        end else if (EXE_MDUStall) begin
          PC_Wr     = 1'b0;
          ID_Wr     = 1'b0;
          EXE_Wr    = 1'b0;
          MEM_Flush = 1'b1;
        end else begin
          if (w_load_use) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Flush = 1'b1;
          end else if (IF_ICacheStall) begin
            PC_Wr    = 1'b0;
            ID_Flush = 1'b1;
          end
          // Annulment only matters when ID is not frozen by a stronger stall.
          if (EXE_BrLikelyAnnul) begin
            ID_Flush = 1'b1;
          end
        end
      end

      S_EXC_WAIT: begin
        if (MEM_DCacheStall) begin
          PC_Wr  = 1'b0;
          ID_Wr  = 1'b0;
          EXE_Wr = 1'b0;
          MEM_Wr = 1'b0;
          WB_Wr  = 1'b0;
        end else begin
          // The held exception fires regardless of WB_ExceptValid now;
          // a reset in this cycle abandons it without redirecting.
          w_exc_action = !rst;
          w_state_nxt  = S_RUN;
        end
      end

      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    if (w_exc_action) begin
      ID_Flush     = 1'b1;
      EXE_Flush    = 1'b1;
      MEM_Flush    = 1'b1;
      WB_Flush     = 1'b1;
      PC_Wr        = 1'b1;
      Exc_Redirect = 1'b1;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic             w_ev_dstall;
  logic             w_ev_mdu;
  logic             w_ev_lduse;
  logic [CNT_W-1:0] r_cnt_dstall;
  logic [CNT_W-1:0] r_cnt_mdu;
  logic [CNT_W-1:0] r_cnt_lduse;
  logic [CNT_W-1:0] r_cnt_exc;

  // Each event is counted only when it is the rule selected in that cycle.
  assign w_ev_dstall = ((r_state == S_RUN) && !WB_ExceptValid && MEM_DCacheStall) ||
                       ((r_state == S_EXC_WAIT) && MEM_DCacheStall);
  assign w_ev_mdu    = (r_state == S_RUN) && !WB_ExceptValid && !MEM_DCacheStall &&
                       EXE_MDUStall;
  assign w_ev_lduse  = (r_state == S_RUN) && !WB_ExceptValid && !MEM_DCacheStall &&
                       !EXE_MDUStall && w_load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_dstall <= '0;
      r_cnt_mdu    <= '0;
      r_cnt_lduse  <= '0;
      r_cnt_exc    <= '0;
    end else begin
      if (w_ev_dstall)  r_cnt_dstall <= r_cnt_dstall + 1'b1;
      if (w_ev_mdu)     r_cnt_mdu    <= r_cnt_mdu + 1'b1;
      if (w_ev_lduse)   r_cnt_lduse  <= r_cnt_lduse + 1'b1;
      if (w_exc_action) r_cnt_exc    <= r_cnt_exc + 1'b1;
    end
  end

  assign Cnt_DStall   = r_cnt_dstall;
  assign Cnt_MDUStall = r_cnt_mdu;
  assign Cnt_LoadUse  = r_cnt_lduse;
  assign Cnt_Exc      = r_cnt_exc;
`else
  assign Cnt_DStall   = '0;
  assign Cnt_MDUStall = '0;
  assign Cnt_LoadUse  = '0;
  assign Cnt_Exc      = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the falling edge. The expected counter values depend on PIPE_STALL_CNT_EN.
module tb_pipe_ctrl;

  localparam int CNT_W = 32;
`ifdef PIPE_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ID_rs, ID_rt, EXE_rt;
  logic             ID_ReadRs, ID_ReadRt, EXE_IsLoad, EXE_MDUStall;
  logic             EXE_BrLikelyAnnul, IF_ICacheStall, MEM_DCacheStall, WB_ExceptValid;
  logic             PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
  logic             ID_Flush, EXE_Flush, MEM_Flush, WB_Flush;
  logic             Exc_Redirect, MDU_Flush;
  logic [CNT_W-1:0] Cnt_DStall, Cnt_MDUStall, Cnt_LoadUse, Cnt_Exc;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_ReadRs(ID_ReadRs), .ID_ReadRt(ID_ReadRt),
    .EXE_IsLoad(EXE_IsLoad), .EXE_rt(EXE_rt), .EXE_MDUStall(EXE_MDUStall),
    .EXE_BrLikelyAnnul(EXE_BrLikelyAnnul), .IF_ICacheStall(IF_ICacheStall),
    .MEM_DCacheStall(MEM_DCacheStall), .WB_ExceptValid(WB_ExceptValid),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
    .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush), .MEM_Flush(MEM_Flush), .WB_Flush(WB_Flush),
    .Exc_Redirect(Exc_Redirect), .MDU_Flush(MDU_Flush),
    .Cnt_DStall(Cnt_DStall), .Cnt_MDUStall(Cnt_MDUStall),
    .Cnt_LoadUse(Cnt_LoadUse), .Cnt_Exc(Cnt_Exc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs as {PC,ID,EXE,MEM,WB}_Wr, {ID,EXE,MEM,WB}_Flush, redirect, MDU_Flush.
  task automatic chk_o(input string tag, input logic [4:0] wr, input logic [3:0] fl,
                       input logic red, input logic mdu);
    chk(tag, {53'd0, PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
              ID_Flush, EXE_Flush, MEM_Flush, WB_Flush, Exc_Redirect, MDU_Flush},
        {53'd0, wr, fl, red, mdu});
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; EXE_rt = 5'd0;
    ID_ReadRs = 1'b0; ID_ReadRt = 1'b0; EXE_IsLoad = 1'b0; EXE_MDUStall = 1'b0;
    EXE_BrLikelyAnnul = 1'b0; IF_ICacheStall = 1'b0; MEM_DCacheStall = 1'b0;
    WB_ExceptValid = 1'b0;
  endtask

  task automatic set_lduse(input logic [4:0] rt);
    EXE_IsLoad = 1'b1; EXE_rt = rt; ID_rs = 5'd5; ID_ReadRs = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    do_reset();

    // Reset state with quiet inputs
    settle();
    chk_o("reset_outputs", 5'b11111, 4'b0000, 1'b0, 1'b0);
    chk("reset_cnt", {Cnt_DStall, Cnt_MDUStall}, 64'd0);
    chk("reset_cnt2", {Cnt_LoadUse, Cnt_Exc}, 64'd0);

    // Load-use on rs
    tick(); set_lduse(5'd5);
    settle(); chk_o("lduse_rs", 5'b00111, 4'b0100, 1'b0, 1'b0);
    tick(); idle();
    settle(); chk_o("lduse_release", 5'b11111, 4'b0000, 1'b0, 1'b0);
    // Load to r0 never stalls
    tick(); set_lduse(5'd0); ID_rs = 5'd0;
    settle(); chk_o("lduse_r0", 5'b11111, 4'b0000, 1'b0, 1'b0);
    // Match on rt
    tick(); idle(); EXE_IsLoad = 1'b1; EXE_rt = 5'd9; ID_rt = 5'd9; ID_ReadRt = 1'b1;
    settle(); chk_o("lduse_rt", 5'b00111, 4'b0100, 1'b0, 1'b0);
    // Matching field that is not read does not stall
    tick(); idle(); EXE_IsLoad = 1'b1; EXE_rt = 5'd9; ID_rs = 5'd9; ID_ReadRs = 1'b0;
    settle(); chk_o("lduse_noread", 5'b11111, 4'b0000, 1'b0, 1'b0);

    // MDU stall for 32 cycles with coincident load-use; counters restart
    tick(); do_reset();
    for (int i = 0; i < 32; i++) begin
      set_lduse(5'd5); EXE_MDUStall = 1'b1;
      settle(); chk_o($sformatf("mdu_stall_%0d", i), 5'b00011, 4'b0010, 1'b0, 1'b0);
      tick();
    end
    EXE_MDUStall = 1'b0;
    settle(); chk_o("lduse_after_mdu", 5'b00111, 4'b0100, 1'b0, 1'b0);
    tick(); idle();
    settle();
    chk("cnt_mdu", Cnt_MDUStall, CNT_ON ? 64'd32 : 64'd0);
    chk("cnt_lduse", Cnt_LoadUse, CNT_ON ? 64'd1 : 64'd0);

    // Exception with no stall
    tick(); WB_ExceptValid = 1'b1;
    settle(); chk_o("exc_flush", 5'b11111, 4'b1111, 1'b1, 1'b0);
    tick(); idle();
    settle(); chk_o("exc_mdu_pulse", 5'b11111, 4'b0000, 1'b0, 1'b1);
    chk("cnt_exc", Cnt_Exc, CNT_ON ? 64'd1 : 64'd0);
    tick();
    settle(); chk_o("exc_mdu_once", 5'b11111, 4'b0000, 1'b0, 1'b0);

    // Exception during D-cache stall: one freeze cycle, three wait cycles, then flush
    tick(); WB_ExceptValid = 1'b1; MEM_DCacheStall = 1'b1;
    settle(); chk_o("exc_dstall_enter", 5'b00000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); WB_ExceptValid = 1'b0;
      settle(); chk_o($sformatf("exc_wait_%0d", i), 5'b00000, 4'b0000, 1'b0, 1'b0);
    end
    tick(); MEM_DCacheStall = 1'b0;
    settle(); chk_o("exc_wait_release", 5'b11111, 4'b1111, 1'b1, 1'b0);
    tick();
    settle(); chk_o("exc_wait_mdu_pulse", 5'b11111, 4'b0000, 1'b0, 1'b1);
    chk("cnt_dstall_wait", Cnt_DStall, CNT_ON ? 64'd3 : 64'd0);
    chk("cnt_exc2", Cnt_Exc, CNT_ON ? 64'd2 : 64'd0);
    tick();
    settle(); chk_o("exc_wait_mdu_once", 5'b11111, 4'b0000, 1'b0, 1'b0);

    // I-cache stall and annulment
    tick(); IF_ICacheStall = 1'b1; EXE_BrLikelyAnnul = 1'b1;
    settle(); chk_o("icache_annul", 5'b01111, 4'b1000, 1'b0, 1'b0);
    tick(); idle(); MEM_DCacheStall = 1'b1; EXE_BrLikelyAnnul = 1'b1;
    settle(); chk_o("dstall_annul", 5'b00001, 4'b0001, 1'b0, 1'b0);
    tick(); idle(); EXE_BrLikelyAnnul = 1'b1;
    settle(); chk_o("annul_only", 5'b11111, 4'b1000, 1'b0, 1'b0);
    tick(); idle(); EXE_MDUStall = 1'b1; EXE_BrLikelyAnnul = 1'b1;
    settle(); chk_o("mdu_annul", 5'b00011, 4'b0010, 1'b0, 1'b0);
    tick(); idle(); set_lduse(5'd5); EXE_BrLikelyAnnul = 1'b1;
    settle(); chk_o("lduse_annul", 5'b00111, 4'b1100, 1'b0, 1'b0);

    // Reset while an exception is pending
    tick(); idle(); WB_ExceptValid = 1'b1; MEM_DCacheStall = 1'b1;
    tick(); WB_ExceptValid = 1'b0;
    settle(); chk_o("pre_rst_wait", 5'b00000, 4'b0000, 1'b0, 1'b0);
    tick(); rst = 1'b1;
    settle(); chk("rst_cycle_redirect", {63'd0, Exc_Redirect}, 64'd0);
    tick(); rst = 1'b0; MEM_DCacheStall = 1'b0;
    settle(); chk_o("post_rst", 5'b11111, 4'b0000, 1'b0, 1'b0);
    chk("post_rst_cnt", {Cnt_DStall, Cnt_Exc}, 64'd0);
    chk("post_rst_cnt2", {Cnt_MDUStall, Cnt_LoadUse}, 64'd0);
    tick();
    settle(); chk_o("post_rst_quiet", 5'b11111, 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline hazard and flush controller for the 5-stage core.
- Generates the per-stage write-enable (`*_Wr`) and flush (`*_Flush`) strobes consumed by the IF/ID/EXE/MEM/WB pipeline registers.
- Resolves load-use hazards, multi-cycle MDU stalls, cache stalls, branch-likely annulment and WB-stage exceptions.
- Holds exception flushes until any outstanding D-cache access completes, and issues a delayed MDU flush pulse.

Parameters:
- `CNT_W`, 32, width of the optional stall performance counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `ID_rs`  in  5  rs field of the instruction in ID.
- `ID_rt`  in  5  rt field of the instruction in ID.
- `ID_ReadRs`  in  1  ID instruction reads rs.
- `ID_ReadRt`  in  1  ID instruction reads rt.
- `EXE_IsLoad`  in  1  EXE instruction is a load (LoadType nonzero).
- `EXE_rt`  in  5  destination of the EXE load.
- `EXE_MDUStall`  in  1  EXE MDU op whose result is not yet ready.
- `EXE_BrLikelyAnnul`  in  1  branch-likely in EXE resolved not-taken; annul the delay slot in ID.
- `IF_ICacheStall`  in  1  instruction fetch not ready.
- `MEM_DCacheStall`  in  1  data access in MEM not complete.
- `WB_ExceptValid`  in  1  exception committed in WB.
- `PC_Wr`, `ID_Wr`, `EXE_Wr`, `MEM_Wr`, `WB_Wr`  out  1 each  stage register write enables.
- `ID_Flush`, `EXE_Flush`, `MEM_Flush`, `WB_Flush`  out  1 each  stage register flushes.
- `Exc_Redirect`  out  1  PC must load the exception vector this cycle.
- `MDU_Flush`  out  1  registered one-cycle abort pulse to the MDU.
- `Cnt_DStall`, `Cnt_MDUStall`, `Cnt_LoadUse`, `Cnt_Exc`  out  `CNT_W` each  performance counters.

Behaviour:
- FSM states: `S_RUN`, `S_EXC_WAIT`. Reset (`rst` = 1 at a `clk` edge) forces:
  - state = `S_RUN`;
  - `MDU_Flush` = 0;
  - counters = 0.
- Write enables and flushes are combinational from the inputs and the state.
- Flush strobes take precedence over write enables in the stage registers. Default each cycle: all `*_Wr` = 1, all `*_Flush` = 0, `Exc_Redirect` = 0.
- Reset mid-operation: any pending `S_EXC_WAIT` is abandoned; no redirect is issued.
- In `S_RUN`, the first matching rule applies:
  1. `WB_ExceptValid` and `MEM_DCacheStall`: all `*_Wr` = 0; next state = `S_EXC_WAIT`.
  2. `WB_ExceptValid` and not `MEM_DCacheStall`:
     - `ID_Flush` = `EXE_Flush` = `MEM_Flush` = `WB_Flush` = 1;
     - `PC_Wr` = 1, `Exc_Redirect` = 1;
     - `MDU_Flush` = 1 on the next cycle.
  3. `MEM_DCacheStall`: `PC_Wr` = `ID_Wr` = `EXE_Wr` = `MEM_Wr` = 0; `WB_Flush` = 1 (bubble into WB).
  4. `EXE_MDUStall`: `PC_Wr` = `ID_Wr` = `EXE_Wr` = 0; `MEM_Flush` = 1.
  5. Load-use: `EXE_IsLoad` and `EXE_rt` != 0 and ((`ID_ReadRs` and `ID_rs` == `EXE_rt`) or (`ID_ReadRt` and `ID_rt` == `EXE_rt`)) gives `PC_Wr` = `ID_Wr` = 0 and `EXE_Flush` = 1.
  6. `IF_ICacheStall`: `PC_Wr` = 0; `ID_Flush` = 1 (bubble into ID).
- `EXE_BrLikelyAnnul` (applied when rules 1-4 do not fire): `ID_Flush` = 1. It ORs with rules 5 and 6.
- In `S_EXC_WAIT`:
  - While `MEM_DCacheStall` = 1: all `*_Wr` = 0.
  - When it drops: perform the rule 2 actions and return to `S_RUN`, irrespective of `WB_ExceptValid` in that cycle.
- `MDU_Flush` is high for exactly one cycle, the cycle after any rule 2 action; never high on consecutive cycles unless exceptions recur.
- Register 0 never causes a load-use stall.
- Simultaneous MDU stall and load-use: rule 4 wins; load-use is re-evaluated once the MDU stall releases.

Optional Feature:
- Macro: `PIPE_STALL_CNT_EN`.
- Defined: four saturating-free `CNT_W`-bit counters, each +1 per cycle in which the event is the selected rule. They wrap to 0 after all-ones.
  - `Cnt_DStall`: rule 3 cycles and `S_EXC_WAIT` cycles.
  - `Cnt_MDUStall`: rule 4.
  - `Cnt_LoadUse`: rule 5.
  - `Cnt_Exc`: each rule 2 action.
- Undefined: counter registers are not synthesised; `Cnt_*` tied to 0.

Test Plan:
- `EXE_IsLoad` = 1, `EXE_rt` = 5, `ID_rs` = 5, `ID_ReadRs` = 1 → `PC_Wr` = `ID_Wr` = 0, `EXE_Flush` = 1 for 1 cycle. Repeat with `EXE_rt` = 0 → no stall.
- `EXE_MDUStall` high for 32 cycles, with a coincident load-use → `PC_Wr`/`ID_Wr`/`EXE_Wr` = 0 and `MEM_Flush` = 1 for 32 cycles. Then `EXE_Flush` = 1 for 1 cycle; `Cnt_MDUStall` = 32, `Cnt_LoadUse` = 1.
- `WB_ExceptValid` pulse with no stall → all four flushes and `Exc_Redirect` = 1 in that cycle; `MDU_Flush` = 1 the next cycle only; `Cnt_Exc` = 1.
- `WB_ExceptValid` while `MEM_DCacheStall` = 1 for 3 more cycles → `S_EXC_WAIT` with all `*_Wr` = 0 for 3 cycles, then flush + redirect in the cycle the stall drops; `MDU_Flush` one cycle later.
- `IF_ICacheStall` = 1 with `EXE_BrLikelyAnnul` = 1 → `PC_Wr` = 0, `ID_Flush` = 1. `MEM_DCacheStall` + `EXE_BrLikelyAnnul` → `ID_Flush` = 0, `WB_Flush` = 1.
- Assert `rst` during `S_EXC_WAIT` → next cycle state `S_RUN`, `MDU_Flush` = 0, counters 0, and no `Exc_Redirect` ever issued.
